// File: rtl/enc83_debounce_pkg.sv
// rtl/enc83_debounce_pkg.sv - shared widths, debounce state type and 8:3 priority encoder
package enc83_pkg;

    localparam int SW_W   = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        STABLE = 1'b0,
        SETTLE = 1'b1
    } db_state_t;

    // Returns {any, code}; ascending scan so the highest set index is the one left standing.
    function automatic logic [CODE_W:0] prio_enc8(input logic [SW_W-1:0] v);
        logic [CODE_W-1:0] code;
        logic              any;
        code = '0;
        any  = 1'b0;
        for (int i = 0; i < SW_W; i++) begin
            if (v[i]) begin
                code = CODE_W'(i);
                any  = 1'b1;
            end
        end
        return {any, code};
    endfunction

endpackage

// File: rtl/enc83_debounce_if.sv
// rtl/enc83_debounce_if.sv - switch/enable inputs and encoded outputs of the debounced encoder
interface enc83_debounce_if;
    import enc83_pkg::*;

    logic              i_en;
    logic [SW_W-1:0]   i_sw;
    logic [CODE_W-1:0] o_code;
    logic              o_valid;
    logic              o_change;

    modport master (
        output i_en,
        output i_sw,
        input  o_code,
        input  o_valid,
        input  o_change
    );

    modport slave (
        input  i_en,
        input  i_sw,
        output o_code,
        output o_valid,
        output o_change
    );

endinterface

// File: rtl/enc83_debounce_sync_2ff.sv
// rtl/enc83_debounce_sync_2ff.sv - two-flop synchroniser for asynchronous switch inputs
module sync_2ff #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

// File: rtl/enc83_debounce.sv
// rtl/enc83_debounce.sv - synchronise and debounce 8 switches as a vector, priority-encode to 3 bits
module enc83_debounce
    import enc83_pkg::*;
#(
    parameter int DB_CYCLES = 50000,
    parameter int DB_CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    enc83_debounce_if.slave  bus
);

    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_CYCLES - 1);

    logic [SW_W-1:0]     w_s;
    db_state_t           r_state;
    db_state_t           w_state_nxt;
    logic [SW_W-1:0]     r_cand;
    logic [SW_W-1:0]     w_cand_nxt;
    logic [SW_W-1:0]     r_deb;
    logic [SW_W-1:0]     w_deb_nxt;
    logic [DB_CNT_W-1:0] r_cnt;
    logic [DB_CNT_W-1:0] w_cnt_nxt;

    logic [CODE_W:0]     w_enc;
    logic [CODE_W-1:0]   w_nxt_code;
    logic                w_nxt_valid;

    sync_2ff #(
        .WIDTH (SW_W)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.i_sw),
        .q     (w_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= STABLE;
            r_cand  <= '0;
            r_deb   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_deb   <= w_deb_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Any difference from the candidate restarts settling, even on the cycle that would have accepted.
    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_deb_nxt   = r_deb;
        w_cnt_nxt   = r_cnt;
        if (w_s != r_cand) begin
            w_cand_nxt  = w_s;
            w_cnt_nxt   = '0;
            w_state_nxt = SETTLE;
        end else if (r_state == SETTLE) begin
            if (r_cnt == CNT_LAST) begin
                w_deb_nxt   = r_cand;
                w_state_nxt = STABLE;
            end else begin
                w_cnt_nxt = r_cnt + DB_CNT_W'(1);
            end
        end
    end

    assign w_enc       = prio_enc8(r_deb);
    assign w_nxt_code  = bus.i_en ? w_enc[CODE_W-1:0] : '0;
    assign w_nxt_valid = bus.i_en & w_enc[CODE_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.o_code   <= '0;
            bus.o_valid  <= 1'b0;
            bus.o_change <= 1'b0;
        end else begin
            bus.o_code   <= w_nxt_code;
            bus.o_valid  <= w_nxt_valid;
            bus.o_change <= ({w_nxt_valid, w_nxt_code} != {bus.o_valid, bus.o_code});
        end
    end

endmodule

// File: tb/tb_enc83_debounce.sv
// tb/tb_enc83_debounce.sv - vector table, corner sequences and random run against a window model
module tb_enc83_debounce;

    localparam int DB = 4;
    localparam int HL = DB + 2;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    enc83_debounce_if bus ();

    enc83_debounce #(
        .DB_CYCLES (DB),
        .DB_CNT_W  (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the accepted vector is whatever value the synchronised switches held for DB+1
    // consecutive edges most recently; the synchronised value is the raw input two edges back.
    logic [7:0] hist [HL];
    logic [7:0] m_deb;
    logic [2:0] exp_code;
    logic       exp_valid;
    logic       exp_change;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < HL; k++) hist[k] <= '0;
            m_deb      <= '0;
            exp_code   <= '0;
            exp_valid  <= 1'b0;
            exp_change <= 1'b0;
        end else begin
            automatic bit       same = 1'b1;
            automatic int       n    = int'(m_deb);
            automatic int       top  = (n == 0) ? 0 : $clog2(n + 1) - 1;
            automatic logic [2:0] nc = bus.i_en ? 3'(top) : 3'd0;
            automatic logic     nv   = bus.i_en && (n != 0);
            for (int j = 1; j <= DB + 1; j++) if (hist[j] != hist[1]) same = 1'b0;
            if (same) m_deb <= hist[1];
            exp_change <= ({nv, nc} != {exp_valid, exp_code});
            exp_code   <= nc;
            exp_valid  <= nv;
            hist[0] <= bus.i_sw;
            for (int k = 1; k < HL; k++) hist[k] <= hist[k-1];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        chk("model_code",   int'(bus.o_code),   int'(exp_code));
        chk("model_valid",  int'(bus.o_valid),  int'(exp_valid));
        chk("model_change", int'(bus.o_change), int'(exp_change));
    endtask

    typedef struct {
        logic [7:0] sw;
        logic       en;
        logic [2:0] code;
        logic       valid;
    } vec_t;

    vec_t tbl [8];
    int   pulses;

    initial begin
        errors = 0;
        checks = 0;
        tbl[0] = '{8'h20, 1'b1, 3'd5, 1'b1};
        tbl[1] = '{8'h85, 1'b1, 3'd7, 1'b1};
        tbl[2] = '{8'h01, 1'b1, 3'd0, 1'b1};
        tbl[3] = '{8'h00, 1'b1, 3'd0, 1'b0};
        tbl[4] = '{8'hFF, 1'b1, 3'd7, 1'b1};
        tbl[5] = '{8'h03, 1'b0, 3'd0, 1'b0};
        tbl[6] = '{8'h03, 1'b1, 3'd1, 1'b1};
        tbl[7] = '{8'h40, 1'b1, 3'd6, 1'b1};

        rst_n      = 1'b0;
        bus.i_en   = 1'b1;
        bus.i_sw   = 8'h00;
        step();
        step();
        chk("reset_code",   int'(bus.o_code),   0);
        chk("reset_valid",  int'(bus.o_valid),  0);
        chk("reset_change", int'(bus.o_change), 0);

        // 1: first acquisition latency
        rst_n    = 1'b1;
        bus.i_sw = 8'h20;
        for (int e = 1; e <= 9; e++) begin
            step();
            chk($sformatf("t1_change_e%0d", e), int'(bus.o_change), (e == 8) ? 1 : 0);
            chk($sformatf("t1_valid_e%0d", e),  int'(bus.o_valid),  (e >= 8) ? 1 : 0);
            if (e >= 8) chk($sformatf("t1_code_e%0d", e), int'(bus.o_code), 5);
        end

        // vector table
        foreach (tbl[i]) begin
            bus.i_sw = tbl[i].sw;
            bus.i_en = tbl[i].en;
            for (int c = 0; c < DB + 6; c++) step();
            chk($sformatf("tbl%0d_code", i),  int'(bus.o_code),  int'(tbl[i].code));
            chk($sformatf("tbl%0d_valid", i), int'(bus.o_valid), int'(tbl[i].valid));
        end

        // 2: multi-bit then bit0 only, single pulse
        bus.i_sw = 8'h85;
        for (int c = 0; c < 10; c++) step();
        chk("t2_code85", int'(bus.o_code), 7);
        chk("t2_valid85", int'(bus.o_valid), 1);
        bus.i_sw = 8'h01;
        pulses   = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            pulses += int'(bus.o_change);
        end
        chk("t2_pulses", pulses, 1);
        chk("t2_code01", int'(bus.o_code), 0);
        chk("t2_valid01", int'(bus.o_valid), 1);

        // 3: bounce, then exact latency after last toggle
        for (int k = 0; k < 9; k++) begin
            bus.i_sw = k[0] ? 8'h10 : 8'h00;
            step();
            chk("t3_bounce_change", int'(bus.o_change), 0);
            step();
            chk("t3_bounce_change", int'(bus.o_change), 0);
        end
        bus.i_sw = 8'h10;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk($sformatf("t3_change_e%0d", e), int'(bus.o_change), (e == 8) ? 1 : 0);
        end
        chk("t3_code", int'(bus.o_code), 4);

        // 4: glitch back to the accepted value
        bus.i_sw = 8'h04;
        for (int c = 0; c < 10; c++) step();
        chk("t4_pre_code", int'(bus.o_code), 2);
        bus.i_sw = 8'h40;
        step();
        step();
        bus.i_sw = 8'h04;
        pulses   = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            pulses += int'(bus.o_change);
            chk("t4_code", int'(bus.o_code), 2);
        end
        chk("t4_pulses", pulses, 0);

        // 5: enable gating
        bus.i_sw = 8'h08;
        for (int c = 0; c < 10; c++) step();
        chk("t5_pre_code", int'(bus.o_code), 3);
        bus.i_en = 1'b0;
        step();
        chk("t5_off_code", int'(bus.o_code), 0);
        chk("t5_off_valid", int'(bus.o_valid), 0);
        chk("t5_off_change", int'(bus.o_change), 1);
        step();
        chk("t5_off_change2", int'(bus.o_change), 0);
        bus.i_en = 1'b1;
        step();
        chk("t5_on_code", int'(bus.o_code), 3);
        chk("t5_on_valid", int'(bus.o_valid), 1);
        chk("t5_on_change", int'(bus.o_change), 1);

        // 6: async reset mid-settle, then full re-acquisition
        bus.i_sw = 8'h02;
        for (int c = 0; c < 4; c++) step();
        rst_n = 1'b0;
        #1;
        chk("t6_async_code", int'(bus.o_code), 0);
        chk("t6_async_valid", int'(bus.o_valid), 0);
        step();
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            chk($sformatf("t6_valid_e%0d", e), int'(bus.o_valid), (e == 8) ? 1 : 0);
        end
        chk("t6_code", int'(bus.o_code), 1);

        // random run, compared against the model every cycle inside step()
        for (int seg = 0; seg < 400; seg++) begin
            bus.i_sw = 8'($urandom);
            if ($urandom_range(7) == 0) bus.i_sw = 8'h00;
            if ($urandom_range(7) == 0) bus.i_en = ~bus.i_en;
            for (int c = 0, n = $urandom_range(1, 8); c < n; c++) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
